// File: rtl/ahb_arbiter_rr.sv
// rtl/ahb_arbiter_rr.sv - AHB bus arbiter: fixed-priority or round-robin, bounded tenure, lock hold, SPLIT masking
module ahb_arbiter_rr #(
    parameter int NUM_MASTERS    = 16,
    parameter int DEFAULT_MASTER = 0,
    parameter bit RR_MODE        = 1'b1,
    parameter int MAX_TENURE     = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic [1:0]             HRESP,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam int                     TEN_W     = (MAX_TENURE < 1) ? 1 : $clog2(MAX_TENURE + 1);
    localparam logic [TEN_W-1:0]       TEN_MAX   = TEN_W'(MAX_TENURE);
    localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [3:0]             hmaster_q;
    logic                   hmastlock_q;
    logic [3:0]             ptr_q, ptr_d;
    logic [TEN_W-1:0]       tenure_q, tenure_d;

    // All per-master vectors are widened to 16 bits so a 4-bit index is always in range.
    logic [15:0] req_w, lock_w, split_w, mask_w, elig_w, owner_oh_w;
    logic [15:0] fp_cand_w, grant_wide_w, mask_set_w, mask_next_w;
    logic [3:0]  owner_idx, fp_idx, rr_idx, rr_cand, next_idx;
    logic        fp_found, rr_found, any_elig, others_elig;
    logic        owner_elig, owner_lock, tenure_left, tenure_expired, hold;

    assign req_w      = 16'(HBUSREQx);
    assign lock_w     = 16'(HLOCKx);
    assign split_w    = 16'(HSPLIT);
    assign mask_w     = 16'(mask_q);
    assign owner_oh_w = 16'(grant_q);
    assign elig_w     = req_w & ~mask_w;
    assign any_elig   = |elig_w;

    // Convert the one-hot grant into the owner index
    always_comb begin
        owner_idx = 4'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner_idx = 4'(i);
        end
    end

    assign owner_elig     = elig_w[owner_idx];
    assign owner_lock     = lock_w[owner_idx];
    assign tenure_left    = (MAX_TENURE == 0) || (tenure_q < TEN_MAX);
    assign hold           = owner_elig && (owner_lock || tenure_left);
    assign tenure_expired = (MAX_TENURE != 0) && (tenure_q == TEN_MAX) && !owner_lock;
    assign others_elig    = |(elig_w & ~owner_oh_w);
    // An expired owner sits out one fixed-priority decision unless nobody else wants the bus.
    assign fp_cand_w      = (tenure_expired && others_elig) ? (elig_w & ~owner_oh_w) : elig_w;

    // Fixed priority: lowest eligible index wins
    always_comb begin
        fp_idx   = DEF_IDX;
        fp_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!fp_found && fp_cand_w[i]) begin
                fp_idx   = 4'(i);
                fp_found = 1'b1;
            end
        end
    end

    // Round robin: first eligible index after the pointer, wrapping; the pointer itself is searched last
    always_comb begin
        rr_idx   = DEF_IDX;
        rr_found = 1'b0;
        rr_cand  = 4'd0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_cand = 4'((int'(ptr_q) + k) % NUM_MASTERS);
            if (!rr_found && elig_w[rr_cand]) begin
                rr_idx   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // Pick the next owner and derive pointer/tenure updates
    always_comb begin
        if (hold) begin
            next_idx = owner_idx;
        end else if (!any_elig) begin
            next_idx = DEF_IDX;
        end else if (RR_MODE) begin
            next_idx = rr_idx;
        end else begin
            next_idx = fp_idx;
        end
        grant_wide_w = 16'd1 << next_idx;
        grant_d      = grant_wide_w[NUM_MASTERS-1:0];
        ptr_d        = (RR_MODE && !hold && any_elig) ? rr_idx : ptr_q;
        if (next_idx != owner_idx) begin
            tenure_d = '0;
        end else if (tenure_q == TEN_MAX) begin
            tenure_d = tenure_q;
        end else begin
            tenure_d = tenure_q + TEN_W'(1);
        end
    end

    // SPLIT response marks the address-phase owner; HSPLIT unmasks; a same-edge set beats the clear
    always_comb begin
        mask_set_w  = (!HREADY && (HRESP == 2'b11)) ? (16'd1 << hmaster_q) : 16'd0;
        mask_next_w = (mask_w & ~split_w) | mask_set_w;
        mask_d      = mask_next_w[NUM_MASTERS-1:0];
    end

    // Split mask tracks slave responses on every edge, stalled or not
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Grant, address-phase owner, pointer and tenure advance only when the bus hands over
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q     <= GRANT_RST;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            ptr_q       <= DEF_IDX;
            tenure_q    <= '0;
        end else if (HREADY) begin
            grant_q     <= grant_d;
            hmaster_q   <= owner_idx;
            hmastlock_q <= owner_lock;
            ptr_q       <= ptr_d;
            tenure_q    <= tenure_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb/tb_ahb_arbiter_rr.sv - directed-vector bench for ahb_arbiter_rr in three parameterisations
module tb_ahb_arbiter_rr;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [15:0] HBUSREQx, HLOCKx, HSPLIT;
    logic [1:0]  HRESP;
    logic        HREADY;

    logic [15:0] g_rr2, g_fp4, g_rr1;
    logic [3:0]  m_rr2, m_fp4, m_rr1;
    logic        l_rr2, l_fp4, l_rr1;

    int vectors;
    int miscompares;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_rr #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .RR_MODE(1'b1), .MAX_TENURE(2)) u_rr2 (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(g_rr2), .HMASTER(m_rr2), .HMASTLOCK(l_rr2)
    );

    ahb_arbiter_rr #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .RR_MODE(1'b0), .MAX_TENURE(4)) u_fp4 (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(g_fp4), .HMASTER(m_fp4), .HMASTLOCK(l_fp4)
    );

    ahb_arbiter_rr #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .RR_MODE(1'b1), .MAX_TENURE(1)) u_rr1 (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(g_rr1), .HMASTER(m_rr1), .HMASTLOCK(l_rr1)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET   = 1'b1;
        HBUSREQx = 16'h0000;
        HLOCKx   = 16'h0000;
        HSPLIT   = 16'h0000;
        HRESP    = 2'b00;
        HREADY   = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (g_rr2 !== 16'h0001) begin miscompares++; $display("FAIL reset_grant_rr2: got %h expected %h", g_rr2, 16'h0001); end
        vectors++; if (m_rr2 !== 4'd0) begin miscompares++; $display("FAIL reset_hmaster_rr2: got %0d expected 0", m_rr2); end
        vectors++; if (l_rr2 !== 1'b0) begin miscompares++; $display("FAIL reset_hmastlock_rr2: got %b expected 0", l_rr2); end
        vectors++; if (g_fp4 !== 16'h0001) begin miscompares++; $display("FAIL reset_grant_fp4: got %h expected %h", g_fp4, 16'h0001); end
        vectors++; if (g_rr1 !== 16'h0001) begin miscompares++; $display("FAIL reset_grant_rr1: got %h expected %h", g_rr1, 16'h0001); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (g_rr2 !== 16'h0001) begin miscompares++; $display("FAIL idle_grant edge%0d: got %h expected %h", k, g_rr2, 16'h0001); end
            vectors++; if (m_rr2 !== 4'd0) begin miscompares++; $display("FAIL idle_hmaster edge%0d: got %0d expected 0", k, m_rr2); end
        end
    endtask

    task automatic test_rr_rotation();
        int exp_idx;
        int prev_idx;
        do_reset();
        prev_idx = 0;
        HBUSREQx = 16'h000E;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_idx = 1 + ((k - 1) / 3) % 3;
            vectors++; if (g_rr2 !== (16'd1 << exp_idx)) begin miscompares++; $display("FAIL rr_grant edge%0d: got %h expected %h", k, g_rr2, 16'd1 << exp_idx); end
            vectors++; if (m_rr2 !== 4'(prev_idx)) begin miscompares++; $display("FAIL rr_hmaster edge%0d: got %0d expected %0d", k, m_rr2, prev_idx); end
            prev_idx = exp_idx;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        HBUSREQx = 16'h0003;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++; if (g_fp4 !== 16'h0001) begin miscompares++; $display("FAIL fp_hold0 edge%0d: got %h expected %h", k, g_fp4, 16'h0001); end
        end
        tick();
        vectors++; if (g_fp4 !== 16'h0002) begin miscompares++; $display("FAIL fp_expire_to1: got %h expected %h", g_fp4, 16'h0002); end
        vectors++; if (m_fp4 !== 4'd0) begin miscompares++; $display("FAIL fp_hmaster_before: got %0d expected 0", m_fp4); end
        HBUSREQx = 16'h0001;
        tick();
        vectors++; if (g_fp4 !== 16'h0001) begin miscompares++; $display("FAIL fp_regain0: got %h expected %h", g_fp4, 16'h0001); end
        vectors++; if (m_fp4 !== 4'd1) begin miscompares++; $display("FAIL fp_hmaster1: got %0d expected 1", m_fp4); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (g_fp4 !== 16'h0001) begin miscompares++; $display("FAIL fp_sole_owner edge%0d: got %h expected %h", k, g_fp4, 16'h0001); end
        end
        HBUSREQx = 16'h0006;
        tick();
        vectors++; if (g_fp4 !== 16'h0002) begin miscompares++; $display("FAIL fp_lowest: got %h expected %h", g_fp4, 16'h0002); end
    endtask

    task automatic test_lock();
        do_reset();
        HBUSREQx = 16'h0004;
        HLOCKx   = 16'h0004;
        tick();
        vectors++; if (g_rr1 !== 16'h0004) begin miscompares++; $display("FAIL lock_first_grant: got %h expected %h", g_rr1, 16'h0004); end
        vectors++; if (l_rr1 !== 1'b0) begin miscompares++; $display("FAIL lock_first_mastlock: got %b expected 0", l_rr1); end
        HBUSREQx = 16'h0006;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (g_rr1 !== 16'h0004) begin miscompares++; $display("FAIL lock_hold edge%0d: got %h expected %h", k, g_rr1, 16'h0004); end
            vectors++; if (m_rr1 !== 4'd2) begin miscompares++; $display("FAIL lock_hmaster edge%0d: got %0d expected 2", k, m_rr1); end
            vectors++; if (l_rr1 !== 1'b1) begin miscompares++; $display("FAIL lock_mastlock edge%0d: got %b expected 1", k, l_rr1); end
        end
        HLOCKx = 16'h0000;
        tick();
        vectors++; if (g_rr1 !== 16'h0002) begin miscompares++; $display("FAIL unlock_grant: got %h expected %h", g_rr1, 16'h0002); end
        vectors++; if (l_rr1 !== 1'b0) begin miscompares++; $display("FAIL unlock_mastlock: got %b expected 0", l_rr1); end
        tick();
        vectors++; if (m_rr1 !== 4'd1) begin miscompares++; $display("FAIL unlock_hmaster: got %0d expected 1", m_rr1); end
    endtask

    task automatic test_split();
        do_reset();
        HBUSREQx = 16'h0008;
        tick();
        vectors++; if (g_rr2 !== 16'h0008) begin miscompares++; $display("FAIL split_own3: got %h expected %h", g_rr2, 16'h0008); end
        tick();
        vectors++; if (m_rr2 !== 4'd3) begin miscompares++; $display("FAIL split_hmaster3: got %0d expected 3", m_rr2); end
        HREADY = 1'b0;
        HRESP  = 2'b11;
        tick();
        vectors++; if (g_rr2 !== 16'h0008) begin miscompares++; $display("FAIL split_stall_grant: got %h expected %h", g_rr2, 16'h0008); end
        HREADY   = 1'b1;
        HRESP    = 2'b00;
        HBUSREQx = 16'h000A;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (g_rr2 !== 16'h0002) begin miscompares++; $display("FAIL split_masked edge%0d: got %h expected %h", k, g_rr2, 16'h0002); end
        end
        HSPLIT = 16'h0008;
        tick();
        HSPLIT = 16'h0000;
        vectors++; if (g_rr2 !== 16'h0002) begin miscompares++; $display("FAIL split_resume_edge: got %h expected %h", g_rr2, 16'h0002); end
        tick();
        vectors++; if (g_rr2 !== 16'h0008) begin miscompares++; $display("FAIL split_regrant3: got %h expected %h", g_rr2, 16'h0008); end
    endtask

    task automatic test_stall_and_reset();
        logic [15:0] reqs [5];
        reqs[0] = 16'h0004;
        reqs[1] = 16'h0008;
        reqs[2] = 16'h0000;
        reqs[3] = 16'h00F0;
        reqs[4] = 16'h0001;
        do_reset();
        HBUSREQx = 16'h0002;
        HLOCKx   = 16'h0002;
        tick();
        vectors++; if (g_rr2 !== 16'h0002) begin miscompares++; $display("FAIL stall_pre_grant: got %h expected %h", g_rr2, 16'h0002); end
        tick();
        vectors++; if (l_rr2 !== 1'b1) begin miscompares++; $display("FAIL stall_pre_mastlock: got %b expected 1", l_rr2); end
        HREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            HBUSREQx = reqs[k];
            tick();
            vectors++; if (g_rr2 !== 16'h0002) begin miscompares++; $display("FAIL stall_grant edge%0d: got %h expected %h", k, g_rr2, 16'h0002); end
            vectors++; if (m_rr2 !== 4'd1) begin miscompares++; $display("FAIL stall_hmaster edge%0d: got %0d expected 1", k, m_rr2); end
        end
        HRESET = 1'b1;
        #2;
        vectors++; if (g_rr2 !== 16'h0001) begin miscompares++; $display("FAIL async_reset_grant: got %h expected %h", g_rr2, 16'h0001); end
        vectors++; if (m_rr2 !== 4'd0) begin miscompares++; $display("FAIL async_reset_hmaster: got %0d expected 0", m_rr2); end
        vectors++; if (l_rr2 !== 1'b0) begin miscompares++; $display("FAIL async_reset_mastlock: got %b expected 0", l_rr2); end
        HBUSREQx = 16'h0000;
        HLOCKx   = 16'h0000;
        HREADY   = 1'b1;
        #2 HRESET = 1'b0;
        tick();
        vectors++; if (g_rr2 !== 16'h0001) begin miscompares++; $display("FAIL post_reset_grant: got %h expected %h", g_rr2, 16'h0001); end
        vectors++; if (m_rr2 !== 4'd0) begin miscompares++; $display("FAIL post_reset_hmaster: got %0d expected 0", m_rr2); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_rr_rotation();
        test_fixed_priority();
        test_lock();
        test_split();
        test_stall_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not reach the summary within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/ahb_arbiter_rr.md
# ahb_arbiter_rr

Parametrised AHB bus arbiter for up to 16 masters, selectable fixed-priority or round-robin arbitration, with bounded tenure, locked-transfer hold and SPLIT masking. It sits between the master request/lock lines and the shared address/control mux. It drives the one-hot grant vector, the current bus-owner index (HMASTER) and HMASTLOCK. It generalises the 16-master arbiter with fairness, tenure limiting and split tracking.

## Interface
- NUM_MASTERS, 16, number of masters, legal 2..16
- DEFAULT_MASTER, 0, master granted when no eligible request exists, < NUM_MASTERS
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)
- MAX_TENURE, 8, max HREADY-high cycles a master may hold the grant while others wait; 0 = unlimited
- HCLK  input  1  bus clock, all state on rising edge
- HRESET  input  1  asynchronous, active-high reset
- HBUSREQx  input  NUM_MASTERS  per-master bus request
- HLOCKx  input  NUM_MASTERS  per-master locked-transfer request
- HSPLIT  input  NUM_MASTERS  slave split-resume, bit i unmasks master i
- HRESP  input  2  slave response; 2'b11 = SPLIT
- HREADY  input  1  transfer-complete / bus-handover qualifier
- HGRANTx  output  NUM_MASTERS  registered one-hot grant
- HMASTER  output  4  index of master owning the address phase
- HMASTLOCK  output  1  current address-phase transfer is locked

## Operation
- Owner = index of the set HGRANTx bit. HGRANTx is always exactly one-hot, never zero.
- Split mask register, NUM_MASTERS bits:
  - Set bit HMASTER on any edge where HREADY=0 and HRESP=2'b11.
  - Clear bit i on any edge where HSPLIT[i]=1.
  - Set and clear of the same bit on the same edge: set wins.
  - Mask updates regardless of HREADY.
- Eligible[i] = HBUSREQx[i] & ~mask[i].
- Hold condition, evaluated on an edge with HREADY=1: owner eligible AND (HLOCKx[owner]=1 OR MAX_TENURE=0 OR tenure < MAX_TENURE).
- Arbitration happens on an edge with HREADY=1 when the hold condition is false:
  - RR_MODE=1: first eligible index searching upward from pointer+1, wrapping modulo NUM_MASTERS. The pointer updates to the winner.
  - RR_MODE=0: lowest eligible index. If tenure expired (tenure = MAX_TENURE, not locked), the current owner is excluded from this one decision unless it is the only eligible master.
  - No eligible master: grant DEFAULT_MASTER, even if it is masked.
- Tenure counter:
  - Increments on each HREADY=1 edge where the owner is retained, saturating at MAX_TENURE.
  - Clears to 0 on an edge where the grant changes index.
  - A re-grant to the same master through arbitration does not clear it.
- A locked owner holds regardless of tenure. A locked owner that becomes masked loses the hold.
- Address-phase tracking, on every edge with HREADY=1:
  - HMASTER <= owner (pre-edge HGRANTx index).
  - HMASTLOCK <= HLOCKx[owner].
- HREADY=0: HGRANTx, HMASTER, HMASTLOCK, the pointer and tenure all hold. Only the mask may change.

## Timing
- Reset values, asserted asynchronously:
  - HGRANTx = 1<<DEFAULT_MASTER
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - mask = 0, tenure = 0, RR pointer = DEFAULT_MASTER
- Release is synchronous to the next HCLK edge.
- Request-to-grant latency is 1 edge when HREADY=1 and the bus is not held.
- Grant-to-HMASTER latency is 1 further HREADY=1 edge.
- Reset mid-transfer returns every output to its reset value immediately. No pending request is remembered.
- SPLIT is seen during the first response cycle (HREADY=0). The split master is therefore excluded at the following HREADY=1 edge.
- Inputs at index ≥ NUM_MASTERS do not exist. HMASTER bits above clog2(NUM_MASTERS) are 0.

## Test plan
- Reset with no requests, DEFAULT_MASTER=0 → HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0, held while HBUSREQx=0.
- RR_MODE=1, HBUSREQx=16'h000E held, HREADY=1 continuously, MAX_TENURE=2 → grant rotates 1,2,3,1…, each master held 3 edges. HMASTER trails HGRANTx by one edge.
- RR_MODE=0, HBUSREQx=16'h0003, MAX_TENURE=4, master 0 unlocked → master 0 holds 5 edges, master 1 granted 1 edge, master 0 regains.
- HLOCKx[2]=1 with HBUSREQx=16'h0006, MAX_TENURE=1 → master 2 keeps the grant indefinitely and HMASTLOCK=1. Drop HLOCKx[2] → master 1 granted at the next HREADY edge.
- Master 3 owns the bus; HREADY=0 with HRESP=2'b11 for one edge, then HREADY=1 → master 3 is not re-granted while HBUSREQx[3]=1. Pulse HSPLIT[3] → master 3 granted at its next turn.
- HREADY=0 for 5 edges with changing requests → HGRANTx and HMASTER stay constant. Assert HRESET mid-stall → outputs return to reset values before the next edge.
